// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the reloadable down-counter (counter_reload)
// and its datapath (counter_dec).
//   mode_e  : load-time mode, one-shot or periodic
//   state_e : control FSM state, IDLE (disarmed) or RUN (armed)
//   IMPL_*  : codes for the IMPLEMENTATION parameter of the datapath
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Decrement as cnt - ena (enable folded into the carry-in).
    localparam int IMPL_CARRY = 0;
    // Decrement via an enable-gated register (mux between hold and cnt-1).
    localparam int IMPL_MUX   = 1;

endpackage : counter_pkg

// File: rtl/counter_dec.sv
// ----------------------------------------------------------------------------
// counter_dec
// WIDTH-bit down-counter datapath with synchronous load, decrement enable and
// zero detect. Two structurally different but cycle-identical decrement
// styles are selectable through IMPLEMENTATION.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, clears the count
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one; caller guarantees cnt_o != 0
//   cnt_o      out  current count
//   zero_o     out  cnt_o == 0
// ----------------------------------------------------------------------------
module counter_dec
    import counter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = IMPL_CARRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    generate
        if (IMPLEMENTATION == IMPL_CARRY) begin : g_carry
            // Enable enters as the subtrahend LSB, so no hold mux is needed.
            always_comb begin
                cnt_d = cnt_q - WIDTH'(dec_i);
                if (load_i) cnt_d = load_val_i;
            end
        end else if (IMPLEMENTATION == IMPL_MUX) begin : g_mux
            always_comb begin
                cnt_d = cnt_q;
                if (load_i)     cnt_d = load_val_i;
                else if (dec_i) cnt_d = cnt_q - WIDTH'(1);
            end
        end else begin : g_bad
            $fatal(1, "counter_dec: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
            assign cnt_d = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule : counter_dec

// File: rtl/counter_reload.sv
// ----------------------------------------------------------------------------
// counter_reload
// Reloadable down-counter timer. A load arms the counter with val and a mode;
// each enabled cycle in RUN counts down, and the enabled cycle at zero is the
// terminal cycle (pls). Periodic mode reloads the captured value, one-shot
// mode disarms and parks at zero. The period is val+1 enabled cycles.
// Optional feature: define COUNTER_RELOAD_STATUS_EN to get a sticky terminal
// flag on sts (cleared by clr); otherwise sts is tied low and clr is ignored.
// Parameters:
//   WIDTH          counter / load value width
//   IMPLEMENTATION datapath style, IMPL_CARRY (0) or IMPL_MUX (1)
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset (highest priority)
//   ena  in   count enable
//   ld   in   load/arm strobe (priority over ena)
//   val  in   load value
//   mod  in   mode captured at load: 0 one-shot, 1 periodic
//   clr  in   sticky status clear
//   cnt  out  current count
//   bsy  out  armed (state RUN)
//   pls  out  terminal pulse, combinational
//   sts  out  sticky terminal flag
// ----------------------------------------------------------------------------
module counter_reload
    import counter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = IMPL_CARRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             ld,
    input  logic [WIDTH-1:0] val,
    input  logic             mod,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             bsy,
    output logic             pls,
    output logic             sts
);

    state_e           state_q;
    logic [WIDTH-1:0] rld_q;
    mode_e            mod_q;

    logic             run;
    logic             zero;
    logic             term;
    logic             reload;
    logic             dec_load;
    logic [WIDTH-1:0] dec_val;
    logic             dec_en;

    assign run  = (state_q == RUN);
    // Terminal cycle; masked during reset so an aborted run emits no pulse.
    assign term = run & ena & zero & ~rst;

    // A coinciding load overrides the periodic reload.
    assign reload   = term & ~ld & (mod_q == MODE_PERIODIC);
    assign dec_load = ld | reload;
    assign dec_val  = ld ? val : rld_q;
    // Decrement only above zero: the zero cycle is handled by reload/disarm.
    assign dec_en   = run & ena & ~zero & ~ld;

    counter_dec #(
        .WIDTH         (WIDTH),
        .IMPLEMENTATION(IMPLEMENTATION)
    ) u_dec (
        .clk       (clk),
        .rst       (rst),
        .load_i    (dec_load),
        .load_val_i(dec_val),
        .dec_i     (dec_en),
        .cnt_o     (cnt),
        .zero_o    (zero)
    );

    // Control FSM with reload value and captured mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rld_q   <= '0;
            mod_q   <= MODE_ONESHOT;
        end else if (ld) begin
            state_q <= RUN;
            rld_q   <= val;
            mod_q   <= mode_e'(mod);
        end else if (term && mod_q == MODE_ONESHOT) begin
            state_q <= IDLE;
        end
    end

    assign bsy = run;
    assign pls = term;

`ifdef COUNTER_RELOAD_STATUS_EN
    logic sts_q;

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)       sts_q <= 1'b0;
        else if (term) sts_q <= 1'b1;
        else if (clr)  sts_q <= 1'b0;
    end

    assign sts = sts_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign sts        = 1'b0;
`endif

endmodule : counter_reload

// File: tb/tb_counter_reload.sv
// Scoreboard bench: two DUT instances (both datapath styles) share stimulus;
// a behavioural model pushes expected outputs per cycle, a monitor pops them.
module tb_counter_reload;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, ena, ld, mod, clr;
    logic [W-1:0] val;
    logic [W-1:0] cnt0, cnt1;
    logic         bsy0, bsy1, pls0, pls1, sts0, sts1;

    always #5 clk = ~clk;

    counter_reload #(.WIDTH(W), .IMPLEMENTATION(0)) u_dut0 (
        .clk(clk), .rst(rst), .ena(ena), .ld(ld), .val(val), .mod(mod),
        .clr(clr), .cnt(cnt0), .bsy(bsy0), .pls(pls0), .sts(sts0));

    counter_reload #(.WIDTH(W), .IMPLEMENTATION(1)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .ld(ld), .val(val), .mod(mod),
        .clr(clr), .cnt(cnt1), .bsy(bsy1), .pls(pls1), .sts(sts1));

    typedef struct {
        logic [W-1:0] cnt;
        logic         bsy;
        logic         pls;
        logic         sts;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference state, expressed in terms of the timer's behaviour.
    logic [W-1:0] m_cnt = '0;
    logic [W-1:0] m_rld = '0;
    bit           m_periodic = 0;
    bit           m_armed = 0;
    bit           m_sts = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected outputs, advance the model.
    task automatic step(input bit r, input bit l, input logic [W-1:0] v,
                        input bit m, input bit e, input bit c);
        exp_t x;
        bit   p;
        @(negedge clk);
        rst = r; ld = l; val = v; mod = m; ena = e; clr = c;
        p = m_armed && e && (m_cnt == 0) && !r;
        x.cnt = m_cnt; x.bsy = m_armed; x.pls = p; x.sts = m_sts; x.cyc = cycle;
        exp_q.push_back(x);
        cycle++;
        if (r) begin
            m_cnt = '0; m_rld = '0; m_periodic = 0; m_armed = 0; m_sts = 0;
        end else begin
            if (l) begin
                m_cnt = v; m_rld = v; m_periodic = m; m_armed = 1;
            end else if (p) begin
                if (m_periodic) m_cnt = m_rld;
                else            m_armed = 0;
            end else if (m_armed && e) begin
                m_cnt = m_cnt - 1'b1;
            end
`ifdef COUNTER_RELOAD_STATUS_EN
            if (p)      m_sts = 1;
            else if (c) m_sts = 0;
`endif
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("cnt0", x.cyc, 32'(cnt0), 32'(x.cnt));
                chk("bsy0", x.cyc, 32'(bsy0), 32'(x.bsy));
                chk("pls0", x.cyc, 32'(pls0), 32'(x.pls));
                chk("sts0", x.cyc, 32'(sts0), 32'(x.sts));
                chk("cnt1", x.cyc, 32'(cnt1), 32'(x.cnt));
                chk("bsy1", x.cyc, 32'(bsy1), 32'(x.bsy));
                chk("pls1", x.cyc, 32'(pls1), 32'(x.pls));
                chk("sts1", x.cyc, 32'(sts1), 32'(x.sts));
            end
        end
    end

    initial begin
        rst = 1; ld = 0; val = '0; mod = 0; ena = 0; clr = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 8'd9, 1, 1, 1);           // reset beats ld/ena/clr
        step(0, 0, 0, 0, 1, 0);              // idle ignores ena

        // Periodic val=3, continuous enable: 3,2,1,0,3,...
        step(0, 1, 8'd3, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0, 1, 0);

        // One-shot val=2: single pulse, then disarmed at 0.
        step(0, 1, 8'd2, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1, 0);

        // Periodic val=5 with toggling enable.
        step(0, 1, 8'd5, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, (i % 2) == 0, 0);

        // Load coinciding with terminal cycle of a val=1 run.
        step(0, 1, 8'd1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 8'd7, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Reset mid-run at cnt=4.
        step(0, 1, 8'd9, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);

        // val=0 periodic: pulse every enabled cycle; clr alongside pulse.
        step(0, 1, 8'd0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);              // clr alone
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_reload
